// File: rtl/ycbcr_packer.sv
// RGB to YCbCr 4:2:2 packer: converts BT.601 full-range, pairs chroma over even/odd pixels
// and emits one 29-bit FIFO word per active pixel at a fixed latency of 3 cycles.
module ycbcr_packer #(
  parameter int          HALF = 640,
  parameter logic [10:0] YMAX = 11'd2047
) (
  input  logic        i_clk_74M,
  input  logic        i_rst,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  input  logic        fifo_full,
  output logic        fifo_write,
  output logic [28:0] o_data,
  output logic        o_overflow
);

  localparam logic [11:0] HALF_W = 12'(HALF);

  function automatic logic [7:0] clamp8(input logic signed [17:0] v);
    logic [7:0] r;
    if (v[17])             r = 8'd0;
    else if (v > 18'sd255) r = 8'hFF;
    else                   r = v[7:0];
    return r;
  endfunction

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  // frame / line / pixel tracking
  logic        de_prev_q, de_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic        par_q, par_d;
  logic [10:0] line_q, line_d;
  logic [10:0] px_q, px_d;

  // input capture
  logic        in_vld_q, in_vld_d;
  logic        in_odd_q, in_odd_d;
  logic [7:0]  in_r_q, in_r_d, in_g_q, in_g_d, in_b_q, in_b_d;
  logic [12:0] in_meta_q, in_meta_d;

  // stage 1: converted pixel
  logic        s1_vld_q, s1_vld_d;
  logic        s1_odd_q, s1_odd_d;
  logic [7:0]  s1_y_q, s1_y_d, s1_cb_q, s1_cb_d, s1_cr_q, s1_cr_d;
  logic [12:0] s1_meta_q, s1_meta_d;

  // stage 2: pixel whose word is formed next
  logic        s2_vld_q, s2_vld_d;
  logic        s2_odd_q, s2_odd_d;
  logic [7:0]  s2_y_q, s2_y_d, s2_cb_q, s2_cb_d, s2_cr_q, s2_cr_d;
  logic [12:0] s2_meta_q, s2_meta_d;

  logic        ev_pend_q, ev_pend_d;
  logic [7:0]  ev_cb_q, ev_cb_d;

  logic        wr_q, wr_d;
  logic [28:0] data_q, data_d;
  logic        ovf_q, ovf_d;

  logic        vs_rise, de_rise, de_fall, par_cur, half_cur;
  logic [10:0] line_cur, px_cur;

  always_comb begin
    vs_rise  = i_vsync & ~vs_prev_q;
    de_rise  = i_de & ~de_prev_q;
    de_fall  = ~i_de & de_prev_q;
    par_cur  = par_q ^ vs_rise;
    line_cur = vs_rise ? 11'd0 : line_q;
    px_cur   = de_rise ? 11'd0 : px_q;
    half_cur = ({1'b0, px_cur} >= HALF_W);

    vs_prev_d = i_vsync;
    de_prev_d = i_de;
    par_d     = par_cur;
    line_d    = line_cur;
    if (de_fall && !vs_rise && (line_q < YMAX))
      line_d = line_q + 11'd1;
    px_d = px_q;
    if (i_de)
      px_d = (px_cur == 11'h7FF) ? px_cur : px_cur + 11'd1;

    in_vld_d  = i_de;
    in_odd_d  = px_cur[0];
    in_r_d    = i_r;
    in_g_d    = i_g;
    in_b_d    = i_b;
    in_meta_d = {par_cur, half_cur, line_cur};
  end

  logic signed [17:0] r_s, g_s, b_s, y_acc, cb_acc, cr_acc;

  always_comb begin
    r_s    = $signed({10'd0, in_r_q});
    g_s    = $signed({10'd0, in_g_q});
    b_s    = $signed({10'd0, in_b_q});
    y_acc  = 18'sd77 * r_s + 18'sd150 * g_s + 18'sd29 * b_s;
    cb_acc = 18'sd128 * b_s - 18'sd43 * r_s - 18'sd85 * g_s;
    cr_acc = 18'sd128 * r_s - 18'sd107 * g_s - 18'sd21 * b_s;

    s1_vld_d  = in_vld_q;
    s1_odd_d  = in_odd_q;
    s1_meta_d = in_meta_q;
    s1_y_d    = clamp8(y_acc >>> 8);
    s1_cb_d   = clamp8((cb_acc >>> 8) + 18'sd128);
    s1_cr_d   = clamp8((cr_acc >>> 8) + 18'sd128);

    s2_vld_d  = s1_vld_q;
    s2_odd_d  = s1_odd_q;
    s2_meta_d = s1_meta_q;
    s2_y_d    = s1_y_q;
    s2_cb_d   = s1_cb_q;
    s2_cr_d   = s1_cr_q;
  end

  logic [7:0] chroma;

  always_comb begin
    chroma    = s2_cr_q;
    ev_pend_d = ev_pend_q;
    ev_cb_d   = ev_cb_q;
    if (s2_vld_q) begin
      if (!s2_odd_q) begin
        // the odd partner sits one stage behind; a lone even keeps its own Cr
        ev_pend_d = 1'b1;
        ev_cb_d   = s2_cb_q;
        if (s1_vld_q && s1_odd_q)
          chroma = avg8(s2_cr_q, s1_cr_q);
      end else begin
        ev_pend_d = 1'b0;
        chroma    = ev_pend_q ? avg8(ev_cb_q, s2_cb_q) : s2_cb_q;
      end
    end
    wr_d   = s2_vld_q & ~fifo_full;
    data_d = wr_d ? {s2_meta_q, chroma, s2_y_q} : data_q;
    ovf_d  = ovf_q | (s2_vld_q & fifo_full);
  end

  always_ff @(posedge i_clk_74M or posedge i_rst) begin
    if (i_rst) begin
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      par_q     <= 1'b0;
      line_q    <= '0;
      px_q      <= '0;
      in_vld_q  <= 1'b0;
      in_odd_q  <= 1'b0;
      in_r_q    <= '0;
      in_g_q    <= '0;
      in_b_q    <= '0;
      in_meta_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_odd_q  <= 1'b0;
      s1_y_q    <= '0;
      s1_cb_q   <= '0;
      s1_cr_q   <= '0;
      s1_meta_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_odd_q  <= 1'b0;
      s2_y_q    <= '0;
      s2_cb_q   <= '0;
      s2_cr_q   <= '0;
      s2_meta_q <= '0;
      ev_pend_q <= 1'b0;
      ev_cb_q   <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      de_prev_q <= de_prev_d;
      vs_prev_q <= vs_prev_d;
      par_q     <= par_d;
      line_q    <= line_d;
      px_q      <= px_d;
      in_vld_q  <= in_vld_d;
      in_odd_q  <= in_odd_d;
      in_r_q    <= in_r_d;
      in_g_q    <= in_g_d;
      in_b_q    <= in_b_d;
      in_meta_q <= in_meta_d;
      s1_vld_q  <= s1_vld_d;
      s1_odd_q  <= s1_odd_d;
      s1_y_q    <= s1_y_d;
      s1_cb_q   <= s1_cb_d;
      s1_cr_q   <= s1_cr_d;
      s1_meta_q <= s1_meta_d;
      s2_vld_q  <= s2_vld_d;
      s2_odd_q  <= s2_odd_d;
      s2_y_q    <= s2_y_d;
      s2_cb_q   <= s2_cb_d;
      s2_cr_q   <= s2_cr_d;
      s2_meta_q <= s2_meta_d;
      ev_pend_q <= ev_pend_d;
      ev_cb_q   <= ev_cb_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fifo_write = wr_q;
  assign o_data     = data_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ycbcr_packer.sv
// Self-checking bench for ycbcr_packer: per-line expected words are queued before driving,
// and a monitor pops them when a word is due three edges after each DE-high sample.
module tb_ycbcr_packer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_vsync = 1'b0;
  logic        i_de = 1'b0;
  logic [7:0]  i_r = '0, i_g = '0, i_b = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_write;
  logic [28:0] o_data;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;
  int drops = 0;
  int wr_cnt = 0;
  int half_cnt = 0;
  logic [28:0] last_data = '0;

  logic [28:0] exp_q[$];
  logic        parity_m = 1'b0;
  logic [10:0] line_m = '0;
  int pr[0:2047], pg[0:2047], pb[0:2047];
  int my[0:2047], mcb[0:2047], mcr[0:2047];
  logic [2:0] hist = '0;

  ycbcr_packer #(.HALF(640), .YMAX(11'd2047)) dut (
    .i_clk_74M (clk),
    .i_rst     (i_rst),
    .i_vsync   (i_vsync),
    .i_de      (i_de),
    .i_r       (i_r),
    .i_g       (i_g),
    .i_b       (i_b),
    .fifo_full (fifo_full),
    .fifo_write(fifo_write),
    .o_data    (o_data),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // monitor: a word is due three edges after each DE-high sample
  always @(posedge clk) begin
    logic [28:0] w;
    #1;
    if (i_rst) begin
      hist = '0;
    end else begin
      if (fifo_write === 1'b1) begin
        wr_cnt++;
        if (o_data[27]) half_cnt++;
        last_data = o_data;
      end
      if (hist[2]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: write=%b data=%h, required a queued word", fifo_write, o_data);
        end else begin
          w = exp_q.pop_front();
          if (fifo_full) begin
            drops++;
            if (fifo_write !== 1'b0) begin
              errors++;
              $display("FAIL dropped_write: write=%b, required 0 while fifo_full", fifo_write);
            end
          end else if (fifo_write !== 1'b1 || o_data !== w) begin
            errors++;
            $display("FAIL word: write=%b data=%h, required write=1 data=%h", fifo_write, o_data, w);
          end
        end
      end else begin
        checks++;
        if (fifo_write !== 1'b0) begin
          errors++;
          $display("FAIL spurious_write: write=%b data=%h, required write=0", fifo_write, o_data);
        end
      end
      hist = {hist[1:0], i_de};
    end
  end

  task automatic vsync_pulse();
    @(negedge clk);
    i_vsync = 1'b1;
    @(negedge clk);
    i_vsync = 1'b0;
    parity_m = ~parity_m;
    line_m = '0;
  endtask

  task automatic drive_line(input int n);
    int c;
    logic [7:0] c8, y8;
    logic hf;
    for (int i = 0; i < n; i++) begin
      my[i]  = clamp((77 * pr[i] + 150 * pg[i] + 29 * pb[i]) >>> 8);
      mcb[i] = clamp(((-43 * pr[i] - 85 * pg[i] + 128 * pb[i]) >>> 8) + 128);
      mcr[i] = clamp(((128 * pr[i] - 107 * pg[i] - 21 * pb[i]) >>> 8) + 128);
    end
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) c = (i + 1 < n) ? (mcr[i] + mcr[i+1]) >> 1 : mcr[i];
      else            c = (mcb[i-1] + mcb[i]) >> 1;
      c8 = c[7:0];
      y8 = my[i][7:0];
      hf = (i >= 640);
      exp_q.push_back({parity_m, hf, line_m, c8, y8});
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_de = 1'b1;
      i_r = pr[i][7:0];
      i_g = pg[i][7:0];
      i_b = pb[i][7:0];
    end
    @(negedge clk);
    i_de = 1'b0;
    if (line_m != 11'd2047) line_m = line_m + 11'd1;
  endtask

  task automatic set_px(input int i, input int r, input int g, input int b);
    pr[i] = r; pg[i] = g; pb[i] = b;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic wait_write(input string name);
    int k = 0;
    while (fifo_write !== 1'b1 && k < 12) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (fifo_write !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: write=%b, required 1", name, fifo_write);
    end
  endtask

  task automatic check_word(input string name, input logic [28:0] req);
    checks++;
    if (fifo_write !== 1'b1 || o_data !== req) begin
      errors++;
      $display("FAIL %s: write=%b data=%h, required write=1 data=%h", name, fifo_write, o_data, req);
    end
  endtask

  task automatic test_reset();
    #1;
    checks += 3;
    if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b, required 0", fifo_write); end
    if (o_data !== 29'd0)    begin errors++; $display("FAIL reset_data: got %h, required 0", o_data); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", o_overflow); end
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_white();
    vsync_pulse();
    set_px(0, 255, 255, 255);
    set_px(1, 255, 255, 255);
    drive_line(2);
    wait_write("white");
    check_word("white_w0", {1'b1, 1'b0, 11'd0, 8'h80, 8'hFF});
    @(posedge clk); #1;
    check_word("white_w1", {1'b1, 1'b0, 11'd0, 8'h80, 8'hFF});
    wait_drain(20);
  endtask

  task automatic test_red_blue();
    set_px(0, 255, 0, 0);
    set_px(1, 0, 0, 255);
    drive_line(2);
    wait_write("redblue");
    check_word("redblue_w0", {1'b1, 1'b0, 11'd1, 8'd181, 8'd76});
    @(posedge clk); #1;
    check_word("redblue_w1", {1'b1, 1'b0, 11'd1, 8'd170, 8'd28});
    wait_drain(20);
  endtask

  task automatic test_odd_line();
    set_px(0, 200, 30, 90);
    set_px(1, 10, 220, 40);
    set_px(2, 0, 0, 0);
    drive_line(3);
    wait_drain(20);
    checks++;
    if (last_data !== {1'b1, 1'b0, 11'd2, 8'd128, 8'd0}) begin
      errors++;
      $display("FAIL odd_tail: got %h, required %h", last_data, {1'b1, 1'b0, 11'd2, 8'd128, 8'd0});
    end
  endtask

  task automatic test_frame();
    int c0, h0;
    logic p0;
    for (int i = 0; i < 1280; i++) set_px(i, 128, 128, 128);
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      c0 = wr_cnt;
      h0 = half_cnt;
      drive_line(1280);
      wait_drain(50);
      checks += 2;
      if (wr_cnt - c0 != 1280) begin errors++; $display("FAIL frame_writes: got %0d, required 1280", wr_cnt - c0); end
      if (half_cnt - h0 != 640) begin errors++; $display("FAIL frame_half: got %0d, required 640", half_cnt - h0); end
    end
    for (int l = 3; l < 720; l++) drive_line(2);
    wait_drain(50);
    checks++;
    if (last_data[26:16] !== 11'd719) begin
      errors++;
      $display("FAIL frame_last_line: got %0d, required 719", last_data[26:16]);
    end
    p0 = last_data[28];
    vsync_pulse();
    drive_line(2);
    wait_drain(20);
    checks++;
    if (last_data[28] !== ~p0) begin
      errors++;
      $display("FAIL frame_parity: got %b, required %b", last_data[28], ~p0);
    end
  endtask

  task automatic test_line_saturation();
    set_px(0, 12, 34, 56);
    vsync_pulse();
    for (int l = 0; l < 2050; l++) drive_line(1);
    wait_drain(20);
    checks++;
    if (last_data[26:16] !== 11'd2047) begin
      errors++;
      $display("FAIL line_saturate: got %0d, required 2047", last_data[26:16]);
    end
  endtask

  task automatic test_overflow();
    int d0;
    @(negedge clk);
    fifo_full = 1'b1;
    repeat (3) @(negedge clk);
    fifo_full = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_idle: got %b, required 0", o_overflow); end
    for (int i = 0; i < 8; i++) set_px(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    d0 = drops;
    fork
      drive_line(8);
      begin
        repeat (5) @(negedge clk);
        fifo_full = 1'b1;
        repeat (2) @(negedge clk);
        fifo_full = 1'b0;
      end
    join
    wait_drain(20);
    checks += 2;
    if (drops - d0 != 2) begin errors++; $display("FAIL ovf_drops: got %0d, required 2", drops - d0); end
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, required 1", o_overflow); end
    for (int i = 0; i < 6; i++) set_px(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    drive_line(6);
    wait_drain(20);
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", o_overflow); end
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_de = 1'b1;
      i_r = 8'(40 * i + 20);
      i_g = 8'(90 - 10 * i);
      i_b = 8'(7 * i);
    end
    @(negedge clk);
    i_de = 1'b0;
    i_rst = 1'b1;
    #1;
    checks += 3;
    if (fifo_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write: got %b, required 0", fifo_write); end
    if (o_data !== 29'd0)    begin errors++; $display("FAIL rst_mid_data: got %h, required 0", o_data); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b, required 0", o_overflow); end
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    parity_m = 1'b0;
    line_m = '0;
    set_px(0, 255, 255, 0);
    set_px(1, 0, 255, 255);
    set_px(2, 255, 0, 255);
    set_px(3, 60, 60, 60);
    drive_line(4);
    wait_drain(20);
    checks++;
    if (last_data[28:16] !== 13'd0) begin
      errors++;
      $display("FAIL rst_restart_meta: got %h, required 0", last_data[28:16]);
    end
  endtask

  initial begin
    test_reset();
    test_white();
    test_red_blue();
    test_odd_line();
    test_frame();
    test_line_saturation();
    test_overflow();
    test_reset_midline();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
